matrix_vec_feeder: RTL and testbench
====================================

// Module: matrix_vec_feeder
// PURPOSE
//   Front-end/back-end sequencer for the combinational 3x3 constant-matrix multiplier (matrix_mult).
//   - Collects a serial stream of input elements via valid/ready into B0..B2.
//   - Holds B0..B2 stable for a programmable settle window (multicycle path through matrix_mult).
//   - Registers C0..C2 and offers them to the downstream consumer via valid/ready.
// PARAMETERS
//   INPUT_BIT_WIDTH   4   width of each vector element (matches matrix_mult input_bit_width)
//   OUTPUT_BIT_WIDTH  16  width of each result element (matches matrix_mult output_bit_width)
//   SETTLE_CYCLES     2   cycles B is held before C is captured; legal range 1..15
// PORTS
//   clk        in   1                 single clock, rising edge
//   rst_n      in   1                 synchronous, active-low reset
//   in_data    in   INPUT_BIT_WIDTH   element; order B0, B1, B2
//   in_valid   in   1                 element valid
//   in_ready   out  1                 element accepted when in_valid & in_ready
//   B0,B1,B2   out  INPUT_BIT_WIDTH   registered vector to matrix_mult
//   C0,C1,C2   in   OUTPUT_BIT_WIDTH  combinational products from matrix_mult
//   R0,R1,R2   out  OUTPUT_BIT_WIDTH  captured results
//   res_valid  out  1                 R0..R2 valid
//   res_ready  in   1                 consumer takes results when res_valid & res_ready
// BEHAVIOUR
//   Reset: state=COLLECT, idx=0, B0..B2=0, R0..R2=0, res_valid=0, settle cnt=0; in_ready=1 next cycle.
//   State COLLECT: in_ready=1. On accept, B[idx]<=in_data, idx++.
//     Accept with idx==2 -> idx<=0, cnt<=SETTLE_CYCLES-1, state SETTLE.
//   State SETTLE: in_ready=0; B0..B2 frozen.
//     cnt>0 -> cnt--. cnt==0 -> R0..R2<=C0..C2, res_valid<=1, state HOLD.
//   Latency: res_valid rises on the SETTLE_CYCLES-th rising edge after the edge accepting B2.
//   State HOLD: res_valid=1; R0..R2 stable until handshake.
//     Overlap: in_ready=(idx!=2), so B0,B1 of the next vector may load; B2 stalls.
//     res_valid&res_ready -> res_valid<=0, state COLLECT (idx kept).
//     Input and result handshakes in the same cycle both take effect.
//   Arithmetic: none; C captured verbatim (already modulo 2^OUTPUT_BIT_WIDTH).
//   in_data ignored when in_valid=0 or in_ready=0; in_valid may drop at any time without penalty.
//   Reset mid-operation: partial vector, pending settle and unread results discarded; all regs -> reset values.
//   Result throughput: at most one vector per (3 + SETTLE_CYCLES) cycles without overlap; 1 + SETTLE_CYCLES + 1 with full HOLD overlap.
// CONFIGURATION
//   MATRIX_FEEDER_CNT_EN defined:
//     - extra output vec_count [15:0], reset 0.
//     - Increments on each result handshake (res_valid&res_ready); wraps 65535->0.
//   Not defined: port and counter absent; all other behaviour identical.
// TESTING (bench instantiates matrix_mult with its standard constants, SETTLE_CYCLES=2)
//   Stream 1,0,0 back-to-back, res_ready=1 -> R=(2755,21889,10840); res_valid 2 edges after B2 accept.
//   Stream 1,1,1 -> R=(49429,31956,8463) (wrap mod 65536).
//   Hold res_ready=0 for 10 cycles, stream 2,3,5 -> in_ready=0 after 2 and 3 are accepted (B2 stalls);
//     R unchanged, then res_ready pulse -> 5 accepted next cycle.
//   Same-cycle res handshake and in handshake in HOLD -> both complete; no element lost or duplicated.
//   Assert rst_n=0 after 2 elements or during SETTLE -> next cycle res_valid=0, B=0, idx=0;
//     fresh 1,0,0 gives (2755,21889,10840).
//   MATRIX_FEEDER_CNT_EN: 3 vectors read -> vec_count=3; preload wrap case 65535 -> 0 after one more read.

Source files
------------

// File: rtl/matrix_vec_feeder.sv
// ----------------------------------------------------------------------------
// matrix_vec_feeder
//
// Sequencer around the combinational 3x3 constant-matrix multiplier
// (matrix_mult). It gathers three serial input elements into B0..B2. It then
// holds B stable for SETTLE_CYCLES so the multicycle path through matrix_mult
// can settle. Finally it captures C0..C2 into R0..R2 and offers them downstream.
//
// Handshake rule (both interfaces): a transfer happens on a rising clk edge
// where valid and ready are both high. The producer may raise or drop valid at
// any time. Ready never depends combinationally on valid.
//
// Parameters
//   INPUT_BIT_WIDTH   element width (B0..B2, in_data)
//   OUTPUT_BIT_WIDTH  result width (C0..C2, R0..R2)
//   SETTLE_CYCLES     cycles B is held before C is captured, legal 1..15
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   in_data/valid/ready   serial element stream, order B0, B1, B2
//   B0..B2                registered vector driven into matrix_mult
//   C0..C2                combinational products from matrix_mult
//   R0..R2, res_valid     captured results offered downstream
//   res_ready             downstream accepts the results
//   vec_count             (MATRIX_FEEDER_CNT_EN only) count of result handshakes
//
// Configuration
//   MATRIX_FEEDER_CNT_EN  adds the 16-bit wrapping vec_count output
// ----------------------------------------------------------------------------
module matrix_vec_feeder #(
    parameter int INPUT_BIT_WIDTH  = 4,
    parameter int OUTPUT_BIT_WIDTH = 16,
    parameter int SETTLE_CYCLES    = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [INPUT_BIT_WIDTH-1:0]  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [INPUT_BIT_WIDTH-1:0]  B0,
    output logic [INPUT_BIT_WIDTH-1:0]  B1,
    output logic [INPUT_BIT_WIDTH-1:0]  B2,
    input  logic [OUTPUT_BIT_WIDTH-1:0] C0,
    input  logic [OUTPUT_BIT_WIDTH-1:0] C1,
    input  logic [OUTPUT_BIT_WIDTH-1:0] C2,
    output logic [OUTPUT_BIT_WIDTH-1:0] R0,
    output logic [OUTPUT_BIT_WIDTH-1:0] R1,
    output logic [OUTPUT_BIT_WIDTH-1:0] R2,
`ifdef MATRIX_FEEDER_CNT_EN
    output logic [15:0]                 vec_count,
`endif
    output logic                        res_valid,
    input  logic                        res_ready
);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    // The settle counter loads SETTLE_CYCLES-1 and captures when it reaches 0.
    // Results therefore appear on the SETTLE_CYCLES-th edge after B2 is taken.
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t                      state_q, state_d;
    logic [1:0]                  idx_q, idx_d;
    logic [3:0]                  cnt_q, cnt_d;
    logic [INPUT_BIT_WIDTH-1:0]  b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
    logic [OUTPUT_BIT_WIDTH-1:0] r0_q, r0_d, r1_q, r1_d, r2_q, r2_d;
    logic                        res_valid_q, res_valid_d;
`ifdef MATRIX_FEEDER_CNT_EN
    logic [15:0]                 vec_count_q, vec_count_d;
`endif
    logic                        accept;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        b0_d        = b0_q;
        b1_d        = b1_q;
        b2_d        = b2_q;
        r0_d        = r0_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        res_valid_d = res_valid_q;
`ifdef MATRIX_FEEDER_CNT_EN
        vec_count_d = vec_count_q;
`endif

        // While a result waits in HOLD, B0 and B1 of the next vector may load.
        // B2 must wait, because taking it would start a new settle window.
        case (state_q)
            ST_COLLECT: in_ready = 1'b1;
            ST_HOLD:    in_ready = (idx_q != 2'd2);
            default:    in_ready = 1'b0;
        endcase
        accept = in_valid && in_ready;

        if (accept) begin
            case (idx_q)
                2'd0:    b0_d = in_data;
                2'd1:    b1_d = in_data;
                default: b2_d = in_data;
            endcase
        end

        case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    if (idx_q == 2'd2) begin
                        idx_d   = 2'd0;
                        cnt_d   = CNT_INIT;
                        state_d = ST_SETTLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    r0_d        = C0;
                    r1_d        = C1;
                    r2_d        = C2;
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    idx_d = idx_q + 2'd1;
                end
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_COLLECT;
`ifdef MATRIX_FEEDER_CNT_EN
                    vec_count_d = vec_count_q + 16'd1;
`endif
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_COLLECT;
            idx_q       <= 2'd0;
            cnt_q       <= 4'd0;
            b0_q        <= '0;
            b1_q        <= '0;
            b2_q        <= '0;
            r0_q        <= '0;
            r1_q        <= '0;
            r2_q        <= '0;
            res_valid_q <= 1'b0;
`ifdef MATRIX_FEEDER_CNT_EN
            vec_count_q <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            r0_q        <= r0_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            res_valid_q <= res_valid_d;
`ifdef MATRIX_FEEDER_CNT_EN
            vec_count_q <= vec_count_d;
`endif
        end
    end

    assign B0        = b0_q;
    assign B1        = b1_q;
    assign B2        = b2_q;
    assign R0        = r0_q;
    assign R1        = r1_q;
    assign R2        = r2_q;
    assign res_valid = res_valid_q;
`ifdef MATRIX_FEEDER_CNT_EN
    assign vec_count = vec_count_q;
`endif

endmodule

// File: tb/tb_matrix_vec_feeder.sv
// ----------------------------------------------------------------------------
// tb_matrix_vec_feeder
//
// Bench for matrix_vec_feeder. A behavioural stand-in for matrix_mult drives C
// from B. Its first column and row sums reproduce the reference results:
//   (1,0,0) -> (2755,21889,10840) and (1,1,1) -> (49429,31956,8463).
// The model tracks these from accepted elements:
//   - the elements buffered so far
//   - the settle delay that is still outstanding
//   - whether a result is pending
// It also keeps a queue of expected result vectors. It is checked against the
// DUT on every falling edge.
// ----------------------------------------------------------------------------
module tb_matrix_vec_feeder;

    localparam int IW     = 4;
    localparam int OW     = 16;
    localparam int SETTLE = 2;

    // Stand-in matrix constants, rows i, columns j.
    localparam int M00 = 2755,  M01 = 20000, M02 = 26674;
    localparam int M10 = 21889, M11 = 5000,  M12 = 5067;
    localparam int M20 = 10840, M21 = 30000, M22 = 33159;

    logic          clk;
    logic          rst_n;
    logic [IW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] b0, b1, b2;
    logic [OW-1:0] c0, c1, c2;
    logic [OW-1:0] r0, r1, r2;
    logic          res_valid;
    logic          res_ready;
`ifdef MATRIX_FEEDER_CNT_EN
    logic [15:0]   vec_count;
`endif

    int checks   = 0;
    int failures = 0;

    matrix_vec_feeder #(
        .INPUT_BIT_WIDTH (IW),
        .OUTPUT_BIT_WIDTH(OW),
        .SETTLE_CYCLES   (SETTLE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .B0       (b0),
        .B1       (b1),
        .B2       (b2),
        .C0       (c0),
        .C1       (c1),
        .C2       (c2),
        .R0       (r0),
        .R1       (r1),
        .R2       (r2),
`ifdef MATRIX_FEEDER_CNT_EN
        .vec_count(vec_count),
`endif
        .res_valid(res_valid),
        .res_ready(res_ready)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- matrix stand-in ----------------
    function automatic logic [47:0] mat_mul(input logic [IW-1:0] x0, x1, x2);
        logic [15:0] y0, y1, y2;
        y0 = 16'(M00 * int'(x0) + M01 * int'(x1) + M02 * int'(x2));
        y1 = 16'(M10 * int'(x0) + M11 * int'(x1) + M12 * int'(x2));
        y2 = 16'(M20 * int'(x0) + M21 * int'(x1) + M22 * int'(x2));
        return {y0, y1, y2};
    endfunction

    always_comb {c0, c1, c2} = mat_mul(b0, b1, b2);

    // ---------------- check helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // ---------------- behavioural model + scoreboard ----------------
    bit            m_ok = 0;
    int            n_buf = 0;
    logic [IW-1:0] b_exp[3];
    int            settle_left = 0;
    bit            res_pending = 0;
    logic [47:0]   exp_q[$];
    int            delivered = 0;
`ifdef MATRIX_FEEDER_CNT_EN
    logic [15:0]   cnt_exp = 16'd0;
`endif

    always @(negedge clk) begin
        bit exp_in_ready;
        bit acc;
        exp_in_ready = (settle_left == 0) && !(res_pending && n_buf == 2);
        if (m_ok) begin
            chk("in_ready", in_ready, exp_in_ready);
            chk("res_valid", res_valid, res_pending);
            chk("b_vec", {b0, b1, b2}, {b_exp[0], b_exp[1], b_exp[2]});
            if (res_pending) begin
                if (exp_q.size() == 0) fail_now("exp_q_empty");
                else chk("r_vec", {r0, r1, r2}, exp_q[0]);
            end
`ifdef MATRIX_FEEDER_CNT_EN
            chk("vec_count", vec_count, cnt_exp);
`endif
        end
        // Advance the model to the state after the coming rising edge.
        if (!rst_n) begin
            m_ok        = 1;
            n_buf       = 0;
            b_exp       = '{default: '0};
            settle_left = 0;
            res_pending = 0;
            exp_q.delete();
`ifdef MATRIX_FEEDER_CNT_EN
            cnt_exp     = 16'd0;
`endif
        end else if (m_ok) begin
            acc = in_valid && exp_in_ready;
            if (res_pending && res_ready) begin
                res_pending = 0;
                void'(exp_q.pop_front());
                delivered++;
`ifdef MATRIX_FEEDER_CNT_EN
                cnt_exp = cnt_exp + 16'd1;
`endif
            end
            if (settle_left > 0) begin
                settle_left--;
                if (settle_left == 0) res_pending = 1;
            end
            if (acc) begin
                b_exp[n_buf] = in_data;
                n_buf++;
                if (n_buf == 3) begin
                    n_buf = 0;
                    exp_q.push_back(mat_mul(b_exp[0], b_exp[1], b_exp[2]));
                    settle_left = SETTLE;
                end
            end
        end
    end

    // ---------------- driver tasks (act at posedge + 1) ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one element and wait until it is taken; in_valid stays high.
    task automatic send_one(input logic [IW-1:0] d);
        int n;
        bit ok;
        in_valid = 1'b1;
        in_data  = d;
        n  = 0;
        ok = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = in_ready;
            step();
            n++;
        end
        if (!ok) fail_now("send_timeout");
    endtask

    task automatic send_vec(input logic [IW-1:0] x0, x1, x2);
        send_one(x0);
        send_one(x1);
        send_one(x2);
        in_valid = 1'b0;
    endtask

    // Count edges from the last accept until res_valid shows, and capture R.
    task automatic wait_res(output logic [47:0] vec, output int edges);
        bit got;
        edges = 0;
        got   = 0;
        vec   = '0;
        while (!got && edges < 50) begin
            @(negedge clk);
            if (res_valid) begin
                got = 1;
                vec = {r0, r1, r2};
            end
            step();
            if (!got) edges++;
        end
        if (!got) fail_now("res_timeout");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [47:0] v;
        int          lat;
        int          rand_start;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        res_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_b", {b0, b1, b2}, 12'd0);
        chk("rst_r", {r0, r1, r2}, 48'd0);
        step();
        rst_n = 1'b1;

        // Unit vector: first column of the matrix.
        send_vec(4'd1, 4'd0, 4'd0);
        wait_res(v, lat);
        chk("lat_100", lat, SETTLE);
        chk("r_100", v, {16'd2755, 16'd21889, 16'd10840});

        // All-ones: row sums wrap modulo 2^16.
        send_vec(4'd1, 4'd1, 4'd1);
        wait_res(v, lat);
        chk("lat_111", lat, SETTLE);
        chk("r_111", v, {16'd49429, 16'd31956, 16'd8463});

        // Result held back: B0,B1 of the next vector load, B2 stalls.
        res_ready = 1'b0;
        send_vec(4'd1, 4'd0, 4'd0);
        wait_res(v, lat);
        send_one(4'd2);
        send_one(4'd3);
        in_valid = 1'b1;
        in_data  = 4'd5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("b2_stall", in_ready, 1'b0);
            chk("r_hold", {r0, r1, r2}, {16'd2755, 16'd21889, 16'd10840});
            step();
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        @(negedge clk);
        chk("b2_resume", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("b_235", {b0, b1, b2}, {4'd2, 4'd3, 4'd5});
        step();
        wait_res(v, lat);
        chk("lat_235", lat, SETTLE - 1);
        chk("r_235", v, mat_mul(4'd2, 4'd3, 4'd5));
        res_ready = 1'b1;
        step();

        // Input and result handshakes in the same HOLD cycle.
        res_ready = 1'b0;
        send_vec(4'd4, 4'd5, 4'd6);
        wait_res(v, lat);
        in_valid  = 1'b1;
        in_data   = 4'd7;
        res_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        send_one(4'd8);
        send_one(4'd9);
        in_valid = 1'b0;
        wait_res(v, lat);
        chk("r_789", v, mat_mul(4'd7, 4'd8, 4'd9));

        // Reset after two elements.
        send_one(4'd7);
        send_one(4'd9);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", res_valid, 1'b0);
        chk("rst_mid_b", {b0, b1, b2}, 12'd0);
        step();
        send_vec(4'd1, 4'd0, 4'd0);
        wait_res(v, lat);
        chk("r_after_rst1", v, {16'd2755, 16'd21889, 16'd10840});

        // Reset during the settle window.
        send_vec(4'd3, 4'd3, 4'd3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_settle_valid", res_valid, 1'b0);
        chk("rst_settle_b", {b0, b1, b2}, 12'd0);
        step();
        repeat (4) step();
        send_vec(4'd1, 4'd0, 4'd0);
        wait_res(v, lat);
        chk("lat_after_rst2", lat, SETTLE);
        chk("r_after_rst2", v, {16'd2755, 16'd21889, 16'd10840});

        // Random traffic, including occasional resets.
        rand_start = delivered;
        for (int i = 0; i < 800; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = 4'($urandom_range(0, 15));
            res_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 149) != 0);
            step();
        end
        in_valid  = 1'b0;
        rst_n     = 1'b1;
        res_ready = 1'b1;
        repeat (10) step();
        chk("rand_results_seen", (delivered - rand_start) > 10, 1'b1);
        chk("drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
